// File: rtl/mips_if_pkg.sv
// Shared types and sizing helpers for the MIPS instruction-fetch stage.
package mips_if_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    REFILL = 1'b1
  } fetch_state_e;

  localparam logic [31:0] NOP              = 32'h0000_0000;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  function automatic int idx_width(input int lines);
    return $clog2(lines);
  endfunction

  // Word-aligned addresses: 2 offset bits, the rest split between index and tag.
  function automatic int tag_width(input int lines);
    return 30 - $clog2(lines);
  endfunction

endpackage

// File: rtl/icache_dm_array.sv
// Direct-mapped, one-word-per-line instruction cache storage.
// Combinational read, single synchronous write port, and synchronous invalidate-all.
module icache_dm_array
  import mips_if_pkg::*;
#(
  parameter int LINES = 16,
  parameter int IDX   = idx_width(LINES),
  parameter int TAG_W = tag_width(LINES)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [IDX-1:0]   i_rd_idx,
  output logic             o_rd_valid,
  output logic [TAG_W-1:0] o_rd_tag,
  output logic [31:0]      o_rd_data,
  input  logic             i_wr_en,
  input  logic [IDX-1:0]   i_wr_idx,
  input  logic [TAG_W-1:0] i_wr_tag,
  input  logic [31:0]      i_wr_data
);

  logic [LINES-1:0] r_valid;
  logic [TAG_W-1:0] r_tag  [LINES];
  logic [31:0]      r_data [LINES];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_valid <= '0;
    end else if (i_wr_en) begin
      r_valid[i_wr_idx] <= 1'b1;
    end
  end

  // Tag and data are deliberately left unreset; the valid bit qualifies them.
  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      r_tag[i_wr_idx]  <= i_wr_tag;
      r_data[i_wr_idx] <= i_wr_data;
    end
  end

  assign o_rd_valid = r_valid[i_rd_idx];
  assign o_rd_tag   = r_tag[i_rd_idx];
  assign o_rd_data  = r_data[i_rd_idx];

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: PC register, direct-mapped I-cache lookup and
// req/ack refill engine towards instruction memory.
module if_fetch_unit
  import mips_if_pkg::*;
#(
  parameter int          LINES    = 16,
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        PCWrite,
  input  logic        PCSrc,
  input  logic [31:0] Branch_Target,
  output logic [31:0] IF_Instruction,
  output logic [31:0] IF_PC_4,
  output logic        IF_Valid,
  output logic        IF_Stall,
  output logic        MEM_REQ,
  output logic [31:0] MEM_ADDR,
  input  logic        MEM_ACK,
  input  logic [31:0] MEM_RDATA
);

  localparam int IDX   = idx_width(LINES);
  localparam int TAG_W = tag_width(LINES);

  fetch_state_e     r_state;
  fetch_state_e     w_state_nxt;
  logic [31:0]      r_pc;
  logic [31:0]      r_mem_addr;
  logic [31:0]      w_mem_addr_nxt;
  logic             r_mem_req;
  logic             w_mem_req_nxt;
  logic             w_wr_en;
  logic             w_line_valid;
  logic [TAG_W-1:0] w_line_tag;
  logic [31:0]      w_line_data;
  logic             w_hit;

  icache_dm_array #(
    .LINES (LINES),
    .IDX   (IDX),
    .TAG_W (TAG_W)
  ) u_array (
    .i_clk      (CLK),
    .i_rst      (RESET),
    .i_rd_idx   (r_pc[IDX+1:2]),
    .o_rd_valid (w_line_valid),
    .o_rd_tag   (w_line_tag),
    .o_rd_data  (w_line_data),
    .i_wr_en    (w_wr_en),
    .i_wr_idx   (r_mem_addr[IDX+1:2]),
    .i_wr_tag   (r_mem_addr[31:IDX+2]),
    .i_wr_data  (MEM_RDATA)
  );

  // Hits are only served from IDLE, so a refill always presents a stall.
  assign w_hit = (r_state == IDLE) && w_line_valid && (w_line_tag == r_pc[31:IDX+2]);

  assign IF_Valid       = w_hit;
  assign IF_Stall       = !w_hit;
  assign IF_Instruction = w_hit ? w_line_data : NOP;
  assign IF_PC_4        = r_pc + 32'd4;
  assign MEM_REQ        = r_mem_req;
  assign MEM_ADDR       = r_mem_addr;

  always_comb begin
    w_state_nxt    = r_state;
    w_mem_req_nxt  = r_mem_req;
    w_mem_addr_nxt = r_mem_addr;
    w_wr_en        = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (!w_hit && !PCSrc) begin
          w_state_nxt    = REFILL;
          w_mem_req_nxt  = 1'b1;
          w_mem_addr_nxt = r_pc;
        end
      end
      REFILL: begin
        // A redirect never cancels the refill; it lands at the latched address.
        if (MEM_ACK) begin
          w_wr_en       = !RESET;
          w_state_nxt   = IDLE;
          w_mem_req_nxt = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state    <= IDLE;
      r_mem_req  <= 1'b0;
      r_mem_addr <= 32'h0;
    end else begin
      r_state    <= w_state_nxt;
      r_mem_req  <= w_mem_req_nxt;
      r_mem_addr <= w_mem_addr_nxt;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_pc <= RESET_PC;
    end else if (PCSrc) begin
      r_pc <= Branch_Target;
    end else if (w_hit && PCWrite) begin
      r_pc <= r_pc + 32'd4;
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: directed scenarios followed by randomized traffic,
// all checked against a line-table reference model of the fetch stage.
module tb_if_fetch_unit;

  localparam int          LINES = 16;
  localparam logic [31:0] RPC   = 32'h0000_0000;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        PCWrite;
  logic        PCSrc;
  logic [31:0] Branch_Target;
  logic [31:0] IF_Instruction;
  logic [31:0] IF_PC_4;
  logic        IF_Valid;
  logic        IF_Stall;
  logic        MEM_REQ;
  logic [31:0] MEM_ADDR;
  logic        MEM_ACK;
  logic [31:0] MEM_RDATA;

  always #5 CLK = ~CLK;

  if_fetch_unit #(.LINES(LINES), .RESET_PC(RPC)) dut (
    .CLK            (CLK),
    .RESET          (RESET),
    .PCWrite        (PCWrite),
    .PCSrc          (PCSrc),
    .Branch_Target  (Branch_Target),
    .IF_Instruction (IF_Instruction),
    .IF_PC_4        (IF_PC_4),
    .IF_Valid       (IF_Valid),
    .IF_Stall       (IF_Stall),
    .MEM_REQ        (MEM_REQ),
    .MEM_ADDR       (MEM_ADDR),
    .MEM_ACK        (MEM_ACK),
    .MEM_RDATA      (MEM_RDATA)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: each line remembers the full word address it holds.
  logic [31:0] m_pc;
  logic [31:0] m_addr;
  bit          m_busy;
  bit          m_ok   [LINES];
  logic [31:0] m_line [LINES];
  logic [31:0] m_dat  [LINES];

  // Memory responder controls
  bit          auto_en;
  bit          rand_lat;
  int          lat;
  int          wcnt;
  bit          force_ack;
  logic [31:0] force_data;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h2010_0001;
    return (a * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
  endfunction

  function automatic int idx_of(input logic [31:0] a);
    return int'((a >> 2) % LINES);
  endfunction

  function automatic bit m_hit();
    int i;
    i = idx_of(m_pc);
    return !m_busy && m_ok[i] && (m_line[i] == m_pc);
  endfunction

  task automatic model_reset();
    m_pc   = RPC;
    m_busy = 0;
    m_addr = 32'h0;
    for (int i = 0; i < LINES; i++) m_ok[i] = 0;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: drive memory response, compare at negedge, advance model at posedge.
  task automatic tick(input bit do_chk);
    bit h;
    int i;
    if (!m_busy) wcnt = 0;
    else wcnt++;
    if (force_ack) begin
      MEM_ACK   = 1'b1;
      MEM_RDATA = force_data;
    end else if (auto_en && m_busy && wcnt >= lat) begin
      MEM_ACK   = 1'b1;
      MEM_RDATA = mem_word(m_addr);
      wcnt      = 0;
      if (rand_lat) lat = $urandom_range(1, 4);
    end else begin
      MEM_ACK   = 1'b0;
      MEM_RDATA = $urandom;
    end
    @(negedge CLK);
    h = m_hit();
    if (do_chk) begin
      check("valid", {31'b0, IF_Valid}, {31'b0, h});
      check("stall", {31'b0, IF_Stall}, {31'b0, !h});
      check("instr", IF_Instruction, h ? m_dat[idx_of(m_pc)] : 32'h0);
      check("pc4", IF_PC_4, m_pc + 32'd4);
      check("req", {31'b0, MEM_REQ}, {31'b0, m_busy});
      check("addr", MEM_ADDR, m_addr);
    end
    @(posedge CLK);
    if (RESET) begin
      model_reset();
    end else begin
      if (m_busy) begin
        if (MEM_ACK) begin
          i = idx_of(m_addr);
          m_ok[i]   = 1;
          m_line[i] = m_addr;
          m_dat[i]  = MEM_RDATA;
          m_busy    = 0;
        end
      end else if (!h && !PCSrc) begin
        m_busy = 1;
        m_addr = m_pc;
      end
      if (PCSrc) m_pc = Branch_Target;
      else if (h && PCWrite) m_pc = m_pc + 32'd4;
    end
    #1;
    PCSrc     = 1'b0;
    force_ack = 0;
    MEM_ACK   = 1'b0;
  endtask

  task automatic redirect(input logic [31:0] t);
    PCSrc         = 1'b1;
    Branch_Target = t;
    tick(1);
  endtask

  initial begin
    int n;
    int r;
    RESET = 1'b1; PCWrite = 1'b1; PCSrc = 1'b0; Branch_Target = 32'h0;
    MEM_ACK = 1'b0; MEM_RDATA = 32'h0;
    force_ack = 0; force_data = 32'h0; auto_en = 1; rand_lat = 0; lat = 3; wcnt = 0;
    model_reset();
    for (int i = 0; i < LINES; i++) begin
      m_line[i] = 32'h0;
      m_dat[i]  = 32'h0;
    end

    tick(0);
    tick(1);
    check("rst_valid", {31'b0, IF_Valid}, 32'h0);
    check("rst_instr", IF_Instruction, 32'h0);
    check("rst_pc4", IF_PC_4, RPC + 32'd4);
    check("rst_req", {31'b0, MEM_REQ}, 32'h0);
    check("rst_addr", MEM_ADDR, 32'h0);

    // Cold start: miss at 0, ACK latency 3
    RESET = 1'b0;
    tick(1);
    check("cold_req", {31'b0, MEM_REQ}, 32'h1);
    check("cold_addr", MEM_ADDR, 32'h0);
    n = 0;
    while (!IF_Valid && n < 10) begin tick(1); n++; end
    check("cold_lat", n, 3);
    check("cold_valid", {31'b0, IF_Valid}, 32'h1);
    check("cold_instr", IF_Instruction, 32'h2010_0001);
    check("cold_pc4", IF_PC_4, 32'h4);
    tick(1);
    check("cold_adv", IF_PC_4, 32'h8);

    // Warm loop over 0x00-0x0C
    n = 0;
    while (m_pc != 32'h10 && n < 60) begin tick(1); n++; end
    check("warm_reach", IF_PC_4, 32'h14);
    redirect(32'h0);
    for (int i = 0; i < 4; i++) begin
      check("warm_hit", {31'b0, IF_Valid}, 32'h1);
      check("warm_req", {31'b0, MEM_REQ}, 32'h0);
      check("warm_pc4", IF_PC_4, 32'(4 * (i + 1)));
      tick(1);
    end

    // PCWrite=0 hold on a hit at 0x08
    redirect(32'h8);
    PCWrite = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("hold_valid", {31'b0, IF_Valid}, 32'h1);
      check("hold_pc4", IF_PC_4, 32'hC);
      check("hold_instr", IF_Instruction, mem_word(32'h8));
      check("hold_req", {31'b0, MEM_REQ}, 32'h0);
      tick(1);
    end
    check("hold_end", IF_PC_4, 32'hC);
    PCWrite = 1'b1;

    // Redirect during refill of 0x10
    redirect(32'h10);
    lat = 4;
    tick(1);
    check("rdr_req", {31'b0, MEM_REQ}, 32'h1);
    check("rdr_addr", MEM_ADDR, 32'h10);
    redirect(32'h40);
    n = 0;
    while (MEM_REQ && n < 10) begin
      check("rdr_hold", MEM_ADDR, 32'h10);
      tick(1);
      n++;
    end
    check("rdr_pc4", IF_PC_4, 32'h44);
    check("rdr_miss", {31'b0, IF_Valid}, 32'h0);
    tick(1);
    check("rdr_req2", {31'b0, MEM_REQ}, 32'h1);
    check("rdr_addr2", MEM_ADDR, 32'h40);
    n = 0;
    while (!IF_Valid && n < 10) begin tick(1); n++; end
    check("rdr_fill", IF_Instruction, mem_word(32'h40));
    redirect(32'h10);
    check("line4_hit", {31'b0, IF_Valid}, 32'h1);
    check("line4_data", IF_Instruction, mem_word(32'h10));
    redirect(32'h0);
    check("evict_miss", {31'b0, IF_Valid}, 32'h0);
    tick(1);
    check("evict_req", {31'b0, MEM_REQ}, 32'h1);
    check("evict_addr", MEM_ADDR, 32'h0);

    // Reset while refill outstanding, late ACK afterwards
    auto_en = 0;
    RESET = 1'b1;
    tick(1);
    RESET = 1'b0;
    check("rr_req", {31'b0, MEM_REQ}, 32'h0);
    check("rr_valid", {31'b0, IF_Valid}, 32'h0);
    check("rr_pc4", IF_PC_4, RPC + 32'd4);
    force_ack = 1; force_data = 32'hFFFF_FFFF;
    tick(1);
    check("rr_req2", {31'b0, MEM_REQ}, 32'h1);
    check("rr_addr2", MEM_ADDR, 32'h0);
    auto_en = 1; lat = 2;
    n = 0;
    while (!IF_Valid && n < 10) begin tick(1); n++; end
    check("rr_data", IF_Instruction, 32'h2010_0001);

    // Stray ACK in IDLE
    PCWrite = 1'b0;
    force_ack = 1; force_data = 32'hFFFF_FFFF;
    tick(1);
    check("stray_valid", {31'b0, IF_Valid}, 32'h1);
    check("stray_instr", IF_Instruction, 32'h2010_0001);
    PCWrite = 1'b1;
    redirect(32'h24);
    check("stray_miss", {31'b0, IF_Valid}, 32'h0);
    tick(1);
    check("stray_req", {31'b0, MEM_REQ}, 32'h1);
    check("stray_addr", MEM_ADDR, 32'h24);

    // PC+4 wrap at the top of the address space
    redirect(32'hFFFF_FFFC);
    n = 0;
    while (!IF_Valid && n < 20) begin tick(1); n++; end
    check("wrap_valid", {31'b0, IF_Valid}, 32'h1);
    check("wrap_pc4", IF_PC_4, 32'h0);
    tick(1);
    check("wrap_pc", IF_PC_4, 32'h4);

    // Randomized traffic
    rand_lat = 1;
    for (int c = 0; c < 3000; c++) begin
      RESET   = ($urandom_range(0, 199) == 0);
      PCWrite = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 9) == 0) begin
        PCSrc = 1'b1;
        r = $urandom_range(0, 19);
        if (r == 0) Branch_Target = 32'hFFFF_FFFC;
        else Branch_Target = 32'(($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2));
      end
      if (!m_busy && $urandom_range(0, 19) == 0) begin
        force_ack  = 1;
        force_data = $urandom;
      end
      tick(1);
    end
    RESET = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/if_fetch_unit.md
# if_fetch_unit

Instruction-fetch stage of the pipelined MIPS core, sitting directly upstream of the IF/ID pipeline register. Holds the PC and looks up a small direct-mapped, one-word-per-line instruction cache. On a miss it runs a req/ack refill against instruction memory. It presents `IF_Instruction`, `IF_PC_4` and a valid/stall indication that the hazard unit uses to drive `IFIDWrite`/`PCWrite`.

## Interface
Parameters:
- `LINES`, 16, number of cache lines; power of two, ≥2; `IDX = log2(LINES)`
- `RESET_PC`, 32'h0000_0000, PC value after reset; word aligned

Ports:
- `CLK`  in  1  single clock, all state on rising edge
- `RESET`  in  1  synchronous, active-high
- `PCWrite`  in  1  from hazard unit; 0 = hold PC
- `PCSrc`  in  1  taken branch/jump redirect
- `Branch_Target`  in  32  redirect address, word aligned
- `IF_Instruction`  out  32  fetched instruction; 32'h0 (NOP) when not valid
- `IF_PC_4`  out  32  PC + 4, always driven
- `IF_Valid`  out  1  `IF_Instruction` is a cache hit for current PC
- `IF_Stall`  out  1  = !IF_Valid; miss or refill in progress
- `MEM_REQ`  out  1  refill request, registered
- `MEM_ADDR`  out  32  refill word address, registered, stable while `MEM_REQ`
- `MEM_ACK`  in  1  one-cycle pulse, `MEM_RDATA` valid same cycle
- `MEM_RDATA`  in  32  refill data

## Operation
- Address split: index = PC[IDX+1:2], tag = PC[31:IDX+2]. Hit = valid[index] && tag match.
- Read path is combinational: `IF_Instruction`, `IF_Valid` and `IF_PC_4` follow PC in the same cycle.
- FSM states, 2:
  - IDLE: on miss (and no `PCSrc` this cycle), latch `MEM_ADDR` <= PC, `MEM_REQ` <= 1, go to REFILL.
  - REFILL: hold `MEM_REQ`/`MEM_ADDR`. On `MEM_ACK`, write data, tag and valid=1 at the index of `MEM_ADDR`, `MEM_REQ` <= 0, go to IDLE.
- `IF_Valid` is 0 throughout REFILL even if the current PC would hit. Hits are served only in IDLE.
- PC update priority: `RESET` > `PCSrc` (PC <= `Branch_Target`) > (`IF_Valid` && `PCWrite`: PC <= PC+4) > hold.
- `PCSrc` overrides `PCWrite`=0.
- Redirect during REFILL:
  - PC updates immediately.
  - The outstanding refill is never cancelled. It completes and fills the line at the latched `MEM_ADDR`.
  - The new PC is looked up after return to IDLE.
- Aliasing: a refill overwrites the line unconditionally. There is no replacement choice.
- `MEM_ACK` in IDLE is ignored; no array write occurs.
- PC+4 wraps modulo 2^32.

## Timing
- Reset values:
  - PC = `RESET_PC`; all valid bits = 0; FSM = IDLE
  - `MEM_REQ` = 0, `MEM_ADDR` = 0
  - `IF_Valid` = 0, `IF_Instruction` = 0, `IF_PC_4` = `RESET_PC`+4
  - Array data/tags are not reset.
- Hit latency: 0 cycles. Sustained 1 instruction/cycle while hitting with `PCWrite`=1.
- Miss timing, with the miss seen in cycle t:
  - `MEM_REQ` rises at t+1.
  - `MEM_ACK` arrives at cycle a ≥ t+1.
  - Line is written at the edge ending cycle a.
  - FSM is in IDLE and the hit is visible at a+1.
  - Miss penalty = (a − t) + 1 cycles.
- `MEM_REQ` is level-held until `MEM_ACK` is sampled. `MEM_REQ` deasserts the cycle after `MEM_ACK`.
- RESET asserted during REFILL:
  - Next edge: FSM = IDLE, `MEM_REQ` = 0, all valid bits cleared.
  - A late `MEM_ACK` is ignored.
- `PCSrc` and `MEM_ACK` in the same REFILL cycle: both take effect at the same edge.

## Structure
- Package `mips_if_pkg`:
  - FSM state enum {IDLE, REFILL}
  - `NOP` = 32'h0
  - `RESET_PC` default
  - tag/index width helper functions
- Sub-module `icache_dm_array`, parameter `LINES`:
  - valid/tag/data storage with combinational read
  - one synchronous write port
  - synchronous clear-all-valid on RESET
- Top level holds the PC register, FSM, hit compare and memory-port registers.

## Test plan
- Cold start, LINES=16, RESET_PC=0, memory ACK latency 3: `MEM_REQ` rises 1 cycle after reset release with `MEM_ADDR`=0. ACK with 32'h2010_0001. Next cycle `IF_Valid`=1, `IF_Instruction`=32'h2010_0001, `IF_PC_4`=4, and PC advances to 4.
- Warm loop: preload 0x00–0x0C by misses, redirect to 0. Four consecutive hits, one per cycle; `MEM_REQ` stays 0.
- `PCWrite`=0 for 3 cycles on a hit at PC=0x08: PC and `IF_Instruction` hold; `IF_Valid` stays 1; no `MEM_REQ`.
- Redirect mid-refill: miss at 0x10; `PCSrc`=1 with `Branch_Target`=0x40 one cycle later.
  - `MEM_ADDR` stays 0x10 until ACK; line 4 is filled.
  - Then a fresh miss issues at 0x40.
  - 0x40 aliases index 0 and evicts 0x00, so a later fetch of 0x00 misses again.
- Reset during REFILL: assert RESET while `MEM_REQ`=1, pulse `MEM_ACK` one cycle after reset release.
  - No array write; PC=`RESET_PC`.
  - A new request issues with `MEM_ADDR`=0.
- Stray `MEM_ACK` in IDLE with data 32'hFFFF_FFFF: no line changes. The next fetch of an uncached address still misses.
